// File: rtl/music_box_pkg.sv
// Shared music box definitions: state numbers, recording window, entry layout
// and the recorder's FSM encoding.
package music_box_pkg;

  localparam int unsigned NOTE_W          = 5;
  localparam int unsigned DUR_W           = 13;
  localparam int unsigned ENTRY_W         = NOTE_W + DUR_W;
  localparam int unsigned STATE_W         = 5;
  localparam int unsigned ADDR_W          = 6;
  localparam int unsigned COUNT_W         = 7;

  localparam int unsigned MB_RECORD_STATE = 2;
  localparam int unsigned MB_PLAY_STATE   = 3;
  localparam int unsigned MB_RECORD_MS    = 5000;

  // One recorded run: note code plus how many ms it was held
  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
  } entry_t;

  typedef enum logic [1:0] {
    REC_IDLE      = 2'd0,
    REC_RECORDING = 2'd1,
    REC_FLUSH     = 2'd2,
    REC_DONE      = 2'd3
  } rec_state_t;

endpackage

// File: rtl/music_box_tick_gen.sv
// Divide-by-DIVIDE pulse generator with synchronous clear; tick_c fires on the
// DIVIDE-th enabled cycle after a clear.
module music_box_tick_gen #(
  parameter int unsigned DIVIDE = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDE - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

  assign tick_c = enable && (count == LAST);

endmodule

// File: rtl/music_box_state_make_recording.sv
// Recording state of the music box: run-length encodes noteIn per 1 ms tick
// into {note, duration} entries written to the recording memory.
module music_box_state_make_recording
  import music_box_pkg::*;
#(
  parameter int unsigned CLOCK_DIVIDE = 50000,
  parameter int unsigned RECORD_MS    = MB_RECORD_MS,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned RECORD_STATE = MB_RECORD_STATE
) (
  input  logic               clock_50Mhz,
  input  logic               reset_n,
  input  logic [STATE_W-1:0] currentState,
  input  logic [NOTE_W-1:0]  noteIn,
  output logic               writeEnable,
  output logic [ADDR_W-1:0]  writeAddress,
  output entry_t             writeData,
  output logic [COUNT_W-1:0] recordedCount,
  output logic               stateComplete,
  output logic [31:0]        debugString
);

  rec_state_t        state;
  logic [DUR_W-1:0]  ms_counter;
  logic [NOTE_W-1:0] run_note;
  logic [DUR_W-1:0]  run_duration;

  logic active_c;
  logic tick_c;
  logic emit_c;
  logic last_tick_c;
  logic fills_c;

  music_box_tick_gen #(.DIVIDE(CLOCK_DIVIDE)) u_tick_gen (
    .clk    (clock_50Mhz),
    .rst_n  (reset_n),
    .clear  (state != REC_RECORDING),
    .enable (state == REC_RECORDING),
    .tick_c (tick_c)
  );

  // Emit the finished run on a note change, or the open run when flushing
  always_comb begin
    active_c    = (currentState == STATE_W'(RECORD_STATE));
    last_tick_c = tick_c && (ms_counter == DUR_W'(RECORD_MS - 1));
    fills_c     = (recordedCount == COUNT_W'(DEPTH - 1));
    emit_c      = 1'b0;
    if (active_c && (run_duration != '0)) begin
      if (state == REC_RECORDING)
        emit_c = tick_c && (noteIn != run_note);
      else if (state == REC_FLUSH)
        emit_c = (recordedCount < COUNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state         <= REC_IDLE;
      writeEnable   <= 1'b0;
      writeAddress  <= '0;
      writeData     <= '0;
      recordedCount <= '0;
      stateComplete <= 1'b0;
      ms_counter    <= '0;
      run_note      <= '0;
      run_duration  <= '0;
    end else begin
      writeEnable <= 1'b0;
      unique case (state)
        REC_IDLE: begin
          stateComplete <= 1'b0;
          if (active_c) begin
            state         <= REC_RECORDING;
            ms_counter    <= '0;
            run_duration  <= '0;
            recordedCount <= '0;
            run_note      <= noteIn;
          end
        end
        REC_RECORDING: begin
          if (!active_c) begin
            state <= REC_IDLE;
          end else if (tick_c) begin
            ms_counter <= ms_counter + DUR_W'(1);
            if (noteIn == run_note) begin
              run_duration <= run_duration + DUR_W'(1);
            end else begin
              run_note     <= noteIn;
              run_duration <= DUR_W'(1);
            end
            // A full buffer wins over the end of the window
            if (emit_c && fills_c)
              state <= REC_DONE;
            else if (last_tick_c)
              state <= REC_FLUSH;
          end
        end
        REC_FLUSH: begin
          state <= active_c ? REC_DONE : REC_IDLE;
        end
        REC_DONE: begin
          if (!active_c) begin
            state         <= REC_IDLE;
            stateComplete <= 1'b0;
          end else begin
            stateComplete <= 1'b1;
          end
        end
        default: state <= REC_IDLE;
      endcase

      if (emit_c) begin
        writeEnable   <= 1'b1;
        writeAddress  <= ADDR_W'(recordedCount);
        writeData     <= '{note: run_note, duration: run_duration};
        recordedCount <= recordedCount + COUNT_W'(1);
      end
    end
  end

  assign debugString = {state, 1'b0, recordedCount, 9'b0, ms_counter};

endmodule

// File: tb/tb_music_box_state_make_recording.sv
// Scoreboard bench for the recorder: expected writes are queued by the stimulus
// and popped by a monitor whenever writeEnable is seen.
module tb_music_box_state_make_recording;

  localparam int unsigned DIV = 4;
  localparam int unsigned RMS = 20;
  localparam int unsigned DEP = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  currentState;
  logic [4:0]  noteIn;
  logic        writeEnable;
  logic [5:0]  writeAddress;
  logic [17:0] writeData;
  logic [6:0]  recordedCount;
  logic        stateComplete;
  logic [31:0] debugString;

  int n_checks = 0;
  int n_fail   = 0;
  logic [23:0] exp_q[$];
  logic [23:0] mon_e;
  logic [4:0]  pat[0:24];

  always #5 clk = ~clk;

  music_box_state_make_recording #(
    .CLOCK_DIVIDE(DIV), .RECORD_MS(RMS), .DEPTH(DEP), .RECORD_STATE(2)
  ) dut (
    .clock_50Mhz  (clk),
    .reset_n      (reset_n),
    .currentState (currentState),
    .noteIn       (noteIn),
    .writeEnable  (writeEnable),
    .writeAddress (writeAddress),
    .writeData    (writeData),
    .recordedCount(recordedCount),
    .stateComplete(stateComplete),
    .debugString  (debugString)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] ent(input int addr, input int note, input int dur);
    return {6'(addr), 5'(note), 13'(dur)};
  endfunction

  // Monitor: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (writeEnable) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(writeEnable), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 32'(writeAddress), 32'(mon_e[23:18]));
        check("write_data", 32'(writeData), 32'(mon_e[17:0]));
      end
    end
  end

  // Enter recording with pat[0]; returns right after the entry edge
  task automatic start_rec();
    @(negedge clk);
    noteIn = pat[0];
    currentState = 5'd2;
    @(posedge clk);
  endtask

  // Present pat[k] for tick k; returns just after the tick-n edge
  task automatic run_ticks(input int n);
    for (int k = 1; k <= n; k++) begin
      #1 noteIn = pat[k];
      repeat (DIV) @(posedge clk);
    end
  endtask

  task automatic leave_rec();
    @(negedge clk);
    currentState = 5'd0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    currentState = 5'd0;
    noteIn = 5'd0;
    repeat (3) @(negedge clk);
    check("reset_we", 32'(writeEnable), 32'd0);
    check("reset_count", 32'(recordedCount), 32'd0);
    check("reset_complete", 32'(stateComplete), 32'd0);
    check("reset_debug", debugString, 32'd0);
    reset_n = 1'b1;

    // Held note: one flush write of the whole window
    for (int k = 0; k <= 24; k++) pat[k] = 5'd5;
    exp_q.push_back(ent(0, 5, 20));
    start_rec();
    run_ticks(20);
    @(negedge clk);
    check("held_complete_early", 32'(stateComplete), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("held_complete", 32'(stateComplete), 32'd1);
    check("held_count", 32'(recordedCount), 32'd1);
    leave_rec();
    check("held_exit_complete", 32'(stateComplete), 32'd0);
    check("held_exit_count", 32'(recordedCount), 32'd1);

    // Note 3 for six ticks, then 7 to the end of the window
    for (int k = 0; k <= 24; k++) pat[k] = (k <= 6) ? 5'd3 : 5'd7;
    exp_q.push_back(ent(0, 3, 6));
    exp_q.push_back(ent(1, 7, 14));
    start_rec();
    run_ticks(20);
    repeat (3) @(negedge clk);
    check("two_runs_count", 32'(recordedCount), 32'd2);
    check("two_runs_complete", 32'(stateComplete), 32'd1);
    leave_rec();

    // Note changes every tick: buffer fills at tick 5, no fifth write
    for (int k = 0; k <= 24; k++) pat[k] = 5'(k + 1);
    exp_q.push_back(ent(0, 2, 1));
    exp_q.push_back(ent(1, 3, 1));
    exp_q.push_back(ent(2, 4, 1));
    exp_q.push_back(ent(3, 5, 1));
    start_rec();
    run_ticks(8);
    @(negedge clk);
    check("full_count", 32'(recordedCount), 32'd4);
    check("full_complete", 32'(stateComplete), 32'd1);
    check("full_debug", debugString, {2'd3, 1'b0, 7'd4, 9'd0, 13'd5});
    leave_rec();

    // Abort after tick 10: entry already written is kept, nothing flushed
    for (int k = 0; k <= 24; k++) pat[k] = (k <= 4) ? 5'd9 : 5'd6;
    exp_q.push_back(ent(0, 9, 4));
    start_rec();
    run_ticks(10);
    #1 currentState = 5'd0;
    noteIn = 5'd1;
    repeat (30) @(negedge clk);
    check("abort_complete", 32'(stateComplete), 32'd0);
    check("abort_debug", debugString, {2'd0, 1'b0, 7'd1, 9'd0, 13'd10});

    // Reset mid-recording, then restart with currentState still 2
    for (int k = 0; k <= 24; k++) pat[k] = (k <= 2) ? 5'd4 : 5'd8;
    exp_q.push_back(ent(0, 4, 2));
    start_rec();
    run_ticks(5);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_we", 32'(writeEnable), 32'd0);
    check("rst_addr", 32'(writeAddress), 32'd0);
    check("rst_data", 32'(writeData), 32'd0);
    check("rst_count", 32'(recordedCount), 32'd0);
    check("rst_debug", debugString, 32'd0);
    for (int k = 0; k <= 24; k++) pat[k] = 5'd8;
    exp_q.push_back(ent(0, 8, 20));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    run_ticks(20);
    repeat (3) @(negedge clk);
    check("restart_count", 32'(recordedCount), 32'd1);
    check("restart_complete", 32'(stateComplete), 32'd1);
    leave_rec();

    repeat (2) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/music_box_state_make_recording.md
MUSIC_BOX_STATE_MAKE_RECORDING -- requirements
Module: music_box_state_make_recording

Interface
REQ-001 SHALL have parameter CLOCK_DIVIDE, default 50000: clock_50Mhz cycles per 1 ms tick.
REQ-002 SHALL have parameter RECORD_MS, default 5000: recording window in ticks.
REQ-003 SHALL have parameter DEPTH, default 64: event buffer entries.
REQ-004 SHALL have parameter RECORD_STATE, default 2: currentState value that activates this block.
REQ-005 clock_50Mhz  in  1  sole clock; every flop is clocked on its rising edge.
REQ-006 reset_n  in  1  reset; asynchronous, active-low.
REQ-007 currentState  in  5  state number from the music box state controller.
REQ-008 noteIn  in  5  current note code from the key decoder; 0 = silence.
REQ-009 writeEnable  out  1  one-cycle write strobe to the recording memory.
REQ-010 writeAddress  out  6  entry index, valid with writeEnable.
REQ-011 writeData  out  18  {note[17:13], durationMs[12:0]}, valid with writeEnable.
REQ-012 recordedCount  out  7  number of entries written (0..DEPTH).
REQ-013 stateComplete  out  1  high when recording is finished, for return to DoNothing.
REQ-014 debugString  out  32  {state[1:0], 1'b0, recordedCount, 9'b0, msCounter[12:0]}.

Function
REQ-015 SHALL implement FSM IDLE, RECORDING, FLUSH, DONE.
REQ-016 IDLE -> RECORDING on the first cycle with currentState==RECORD_STATE; on entry, clear the prescaler, msCounter, runDuration and recordedCount, and set runNote=noteIn.
REQ-017 In RECORDING the prescaler SHALL pulse tick once every CLOCK_DIVIDE cycles; the first tick comes CLOCK_DIVIDE cycles after entry.
REQ-018 On tick with noteIn==runNote: runDuration += 1; msCounter += 1.
REQ-019 On tick with noteIn!=runNote: emit entry {runNote, runDuration} if runDuration>0; set runNote=noteIn and runDuration=1; msCounter += 1.
REQ-020 Emitting an entry SHALL assert writeEnable for exactly one cycle, with writeAddress=recordedCount (old value), and increment recordedCount in the same edge.
REQ-021 When msCounter reaches RECORD_MS, go RECORDING -> FLUSH; any note change on that same tick is processed first.
REQ-022 FLUSH SHALL emit the final run if runDuration>0 and recordedCount<DEPTH, then go to DONE next cycle; FLUSH lasts 1 cycle.
REQ-023 When recordedCount reaches DEPTH, SHALL go directly to DONE; no further writes occur (no overflow, no address wrap).
REQ-024 DONE SHALL hold stateComplete=1 while currentState==RECORD_STATE; when currentState!=RECORD_STATE, go to IDLE with stateComplete=0 in the next cycle.
REQ-025 currentState leaving RECORD_STATE during RECORDING/FLUSH SHALL abort to IDLE with no flush write; recordedCount keeps entries already written.
REQ-026 recordedCount SHALL hold its value in IDLE until the next entry into RECORDING.
REQ-027 Durations never exceed RECORD_MS (<=8191), so no saturation logic; stateComplete is never high outside DONE.

Reset
REQ-028 On reset_n low: state=IDLE; writeEnable, writeAddress, writeData, recordedCount, stateComplete, msCounter, prescaler, runNote, runDuration all 0, asynchronously.
REQ-029 Reset deassertion mid-recording SHALL restart from IDLE; no partial write is emitted.

Structure
REQ-030 Shared package music_box_pkg SHALL hold the state number constants (RECORD_STATE=2, PLAY_STATE=3), RECORD_MS, the entry typedef (note 5b, duration 13b) and the note width.
REQ-031 The prescaler SHALL be a sub-module music_box_tick_gen (divide-by-N pulse, synchronous clear), reusable by the playback state.

Verification (CLOCK_DIVIDE=4, RECORD_MS=20, DEPTH=4 unless noted)
REQ-032 noteIn=5 held, currentState=2 -> a single write {5,20} at address 0 in FLUSH; stateComplete=1 from the next cycle; recordedCount=1.
REQ-033 noteIn=3 for ticks 1-6, then 7 -> writes {3,6} @0 and {7,14} @1; recordedCount=2.
REQ-034 noteIn changes on every tick -> exactly 4 writes at addresses 0..3, then DONE before msCounter reaches 20; no 5th strobe.
REQ-035 currentState 2->0 at tick 10 -> no further writes, stateComplete stays 0, FSM in IDLE, recordedCount retained.
REQ-036 reset_n pulsed low for 2 cycles mid-RECORDING -> all outputs 0 immediately; with currentState still 2, recording restarts and recordedCount is cleared.
REQ-037 Defaults (50000, 5000), noteIn constant -> stateComplete rises 250,000,001..250,000,003 cycles after entry (±1); entry duration 5000.
